// File: rtl/mem_seq_ctrl_if.sv
// Bus between mem_seq_ctrl and its environment (command decoder, BRAM, systolic array).
// MEM_SEQ_CTRL_PERF_CNT_EN adds the perf_cycles/perf_stalls counters.
interface mem_seq_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 11
);
  logic              calc_init;
  logic              calc_abort;
  logic [2:0]        mem_mode;
  logic [SIZE_W-1:0] matrix_size;
  logic [ADDR_W-1:0] base_a, base_s, base_b;
  logic              hash_ready;
  logic [DATA_W-1:0] rd_a, rd_s, rd_b;
  logic [ADDR_W-1:0] addr_a, addr_s, addr_b_rd, addr_b_wr;
  logic              wen_b;
  logic [DATA_W-1:0] data_left, data_right, data_adder;
  logic              sys_mode, sys_state, sys_enable;
  logic              busy, done, err;
  logic [2:0]        state;
`ifdef MEM_SEQ_CTRL_PERF_CNT_EN
  logic [31:0]       perf_cycles, perf_stalls;
`endif

  modport master (
    input  calc_init, calc_abort, mem_mode, matrix_size, base_a, base_s, base_b,
           hash_ready, rd_a, rd_s, rd_b,
    output addr_a, addr_s, addr_b_rd, addr_b_wr, wen_b, data_left, data_right, data_adder,
           sys_mode, sys_state, sys_enable, busy, done, err, state
`ifdef MEM_SEQ_CTRL_PERF_CNT_EN
    , output perf_cycles, perf_stalls
`endif
  );

  modport slave (
    output calc_init, calc_abort, mem_mode, matrix_size, base_a, base_s, base_b,
           hash_ready, rd_a, rd_s, rd_b,
    input  addr_a, addr_s, addr_b_rd, addr_b_wr, wen_b, data_left, data_right, data_adder,
           sys_mode, sys_state, sys_enable, busy, done, err, state
`ifdef MEM_SEQ_CTRL_PERF_CNT_EN
    , input perf_cycles, perf_stalls
`endif
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Address/sequencing controller for the systolic multiply array (A*S and S*A over LANES lanes).
// Optional busy/stall counters under MEM_SEQ_CTRL_PERF_CNT_EN.
module mem_seq_ctrl #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int SIZE_W   = 11,
  parameter int A_STRIDE = 64,
  parameter int S_STRIDE = 32,
  parameter int DRAIN    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_seq_ctrl_if.master bus
);
  localparam int LW     = $clog2(LANES);
  localparam int LINE_W = SIZE_W + 1;
  localparam logic [ADDR_W-1:0] A_STR  = ADDR_W'(A_STRIDE);
  localparam logic [ADDR_W-1:0] S_STR  = ADDR_W'(S_STRIDE);
  localparam logic [ADDR_W-1:0] ROW_B  = ADDR_W'(LANES * A_STRIDE);
  localparam logic [LINE_W-1:0] DRAIN_L = LINE_W'(DRAIN);
  localparam logic [LINE_W-1:0] ONE_L  = LINE_W'(1);
  localparam logic [LW-1:0]     LANE_MAX = LW'(LANES - 1);
  localparam logic [DATA_W-1:0] ZERO_D = '0;

  typedef enum logic [2:0] {
    IDLE = 3'd0, AS_CALC = 3'd1, AS_SAVE = 3'd2, SA_LOAD = 3'd3, SA_CALC = 3'd4, DONE = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [LW-1:0]     lane, lane_nx;
  logic [LINE_W-1:0] line, line_nx, n_ext;
  logic [SIZE_W-1:0] cfg_n;
  logic [ADDR_W-1:0] cfg_base_a, cfg_base_s, cfg_base_b, a_plane, s_plane, wr_addr;
  logic              cfg_as, wr_pend, err_q, save_wr;
  logic              stall, lane_last, accept, mode_ok;

  assign n_ext     = LINE_W'(cfg_n);
  assign lane_last = (lane == LANE_MAX);
  assign stall     = !bus.hash_ready && (state == AS_CALC || state == SA_CALC);
  assign accept    = (state == IDLE) && bus.calc_init && !bus.calc_abort;
  assign mode_ok   = (bus.mem_mode == 3'd1) || (bus.mem_mode == 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane       <= '0;
      line       <= '0;
      cfg_n      <= '0;
      cfg_as     <= 1'b0;
      cfg_base_a <= '0;
      cfg_base_s <= '0;
      cfg_base_b <= '0;
      a_plane    <= '0;
      s_plane    <= '0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      lane  <= lane_nx;
      line  <= line_nx;
      err_q <= accept && !mode_ok;
      if (accept && mode_ok) begin
        cfg_n      <= bus.matrix_size;
        cfg_as     <= (bus.mem_mode == 3'd1);
        cfg_base_a <= bus.base_a;
        cfg_base_s <= bus.base_s;
        cfg_base_b <= bus.base_b;
        a_plane    <= ADDR_W'(bus.matrix_size) * A_STR;
        s_plane    <= ADDR_W'(bus.matrix_size) * S_STR;
      end
      // B write-back trails the B read by one unstalled cycle; may land in DONE
      if (bus.calc_abort) begin
        wr_pend <= 1'b0;
      end else if (!stall) begin
        wr_pend <= (state == SA_CALC) && (line >= DRAIN_L);
        wr_addr <= bus.addr_b_rd;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    lane_nx        = lane_last ? '0 : lane + LW'(1);
    line_nx        = lane_last ? line + ONE_L : line;
    save_wr        = 1'b0;
    bus.addr_a     = '0;
    bus.addr_s     = '0;
    bus.addr_b_rd  = '0;
    bus.addr_b_wr  = '0;
    bus.data_left  = ZERO_D;
    bus.data_right = ZERO_D;
    bus.data_adder = ZERO_D;
    bus.sys_state  = 1'b0;
    case (state)
      IDLE: begin
        lane_nx = '0;
        line_nx = '0;
        if (bus.calc_init) begin
          if (bus.mem_mode == 3'd1)
            state_nx = (bus.matrix_size == '0) ? DONE : AS_CALC;
          else if (bus.mem_mode == 3'd2)
            state_nx = (bus.matrix_size == '0) ? DONE : SA_LOAD;
        end
      end
      AS_CALC: begin
        bus.sys_state  = 1'b1;
        bus.addr_a     = cfg_base_a + ADDR_W'(line) * A_STR + ADDR_W'(lane) * a_plane;
        bus.addr_s     = cfg_base_s + ADDR_W'(line) * S_STR + ADDR_W'(lane) * s_plane;
        bus.data_left  = bus.rd_a;
        bus.data_right = bus.rd_s;
        if (lane_last && line == n_ext - ONE_L) state_nx = AS_SAVE;
      end
      AS_SAVE: begin
        bus.sys_state = (line != DRAIN_L - ONE_L);
        if (line == DRAIN_L - ONE_L) begin
          save_wr       = 1'b1;
          bus.addr_b_wr = cfg_base_b + ADDR_W'(lane) * ROW_B;
          if (lane_last) state_nx = DONE;
        end
      end
      SA_LOAD: begin
        bus.addr_s     = cfg_base_s + ADDR_W'(LANE_MAX - lane) * s_plane;
        bus.data_right = bus.rd_s;
        if (lane_last) state_nx = SA_CALC;
      end
      SA_CALC: begin
        bus.sys_state = 1'b1;
        if (line < n_ext) begin
          bus.addr_a    = cfg_base_a + ADDR_W'(line) * A_STR + ADDR_W'(lane) * a_plane;
          bus.data_left = bus.rd_a;
        end
        if (line >= DRAIN_L) begin
          bus.addr_b_rd  = cfg_base_b + ADDR_W'(line - DRAIN_L) * A_STR + ADDR_W'(lane) * a_plane;
          bus.data_adder = bus.rd_b;
        end
        if (lane_last && line == n_ext + DRAIN_L - ONE_L) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) begin
      lane_nx = '0;
      line_nx = '0;
    end
    if (stall) begin
      state_nx = state;
      lane_nx  = lane;
      line_nx  = line;
    end
    if (bus.calc_abort) begin
      state_nx = IDLE;
      lane_nx  = '0;
      line_nx  = '0;
    end
    if (wr_pend) bus.addr_b_wr = wr_addr;
    bus.wen_b      = (save_wr || wr_pend) && !stall && !bus.calc_abort;
    bus.busy       = (state != IDLE) && (state != DONE);
    bus.done       = (state == DONE);
    bus.sys_enable = (state != IDLE) && !stall;
    bus.sys_mode   = cfg_as;
    bus.err        = err_q;
    bus.state      = state;
  end

`ifdef MEM_SEQ_CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (bus.busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (stall && perf_stalls != '1)    perf_stalls <= perf_stalls + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles;
  assign bus.perf_stalls = perf_stalls;
`endif
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Randomized bench for mem_seq_ctrl against a transaction-level step model built from the address rules.
module tb_mem_seq_ctrl;
  localparam int LANES = 4, DRAIN = 4, A_STRIDE = 64, S_STRIDE = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_seq_ctrl_if #(.DATA_W(64), .ADDR_W(32), .SIZE_W(11)) bus ();

  mem_seq_ctrl #(
    .LANES(LANES), .DATA_W(64), .ADDR_W(32), .SIZE_W(11),
    .A_STRIDE(A_STRIDE), .S_STRIDE(S_STRIDE), .DRAIN(DRAIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ph: 0 = stallable compute step, 1 = other busy step, 2 = done
  typedef struct {
    int          ph;
    bit          a_v, s_v, b_v, ss, zero_ops;
    logic [31:0] a, s, b;
  } step_t;

  step_t       q[$];
  logic [31:0] wq[$];
  logic [31:0] ba, bs, bb;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic build(input int mode, input int n);
    step_t st;
    logic [31:0] ap, sp;
    ap = 32'(n * A_STRIDE);
    sp = 32'(n * S_STRIDE);
    q.delete();
    wq.delete();
    if (n > 0 && mode == 1) begin
      for (int line = 0; line < n; line++)
        for (int ln = 0; ln < LANES; ln++) begin
          st = '{default: '0};
          st.ph = 0; st.ss = 1'b1;
          st.a_v = 1'b1; st.a = ba + 32'(line * A_STRIDE) + 32'(ln) * ap;
          st.s_v = 1'b1; st.s = bs + 32'(line * S_STRIDE) + 32'(ln) * sp;
          q.push_back(st);
        end
      for (int g = 0; g < DRAIN; g++)
        for (int ln = 0; ln < LANES; ln++) begin
          st = '{default: '0};
          st.ph = 1; st.ss = (g != DRAIN - 1); st.zero_ops = 1'b1;
          q.push_back(st);
          if (g == DRAIN - 1) wq.push_back(bb + 32'(ln * LANES * A_STRIDE));
        end
    end else if (n > 0 && mode == 2) begin
      for (int k = 0; k < LANES; k++) begin
        st = '{default: '0};
        st.ph = 1; st.s_v = 1'b1; st.s = bs + 32'(LANES - 1 - k) * sp;
        q.push_back(st);
      end
      for (int line = 0; line < n + DRAIN; line++)
        for (int ln = 0; ln < LANES; ln++) begin
          st = '{default: '0};
          st.ph = 0; st.ss = 1'b1;
          st.a_v = (line < n);
          st.a = ba + 32'(line * A_STRIDE) + 32'(ln) * ap;
          st.b_v = (line >= DRAIN);
          st.b = bb + 32'((line - DRAIN) * A_STRIDE) + 32'(ln) * ap;
          q.push_back(st);
          if (st.b_v) wq.push_back(st.b);
        end
    end
    st = '{default: '0};
    st.ph = 2;
    q.push_back(st);
  endtask

  // stall_kind: 0 none, 1 random, 2 five low cycles at cycles 5..9
  task automatic run_op(input int mode, input int n, input int stall_kind, input int abort_at,
                        output int busy_cyc, output int wr_cyc);
    step_t h;
    int cyc;
    bit stalled;
    build(mode, n);
    @(posedge clk); #1;
    bus.mem_mode = 3'(mode); bus.matrix_size = 11'(n);
    bus.base_a = ba; bus.base_s = bs; bus.base_b = bb;
    bus.calc_init = 1'b1;
    @(posedge clk); #1;
    bus.calc_init = 1'b0;
    bus.mem_mode = 3'($urandom); bus.matrix_size = 11'($urandom);
    bus.base_a = $urandom; bus.base_s = $urandom; bus.base_b = $urandom;
    cyc = 0; busy_cyc = 0; wr_cyc = 0;
    while (q.size() > 0 && cyc < 500) begin
      case (stall_kind)
        0:       bus.hash_ready = 1'b1;
        1:       bus.hash_ready = ($urandom_range(0, 3) != 0);
        default: bus.hash_ready = !(cyc >= 5 && cyc < 10);
      endcase
      bus.rd_a = {$urandom, $urandom} | 64'd1;
      bus.rd_s = {$urandom, $urandom} | 64'd1;
      bus.rd_b = {$urandom, $urandom} | 64'd1;
      bus.calc_init = ($urandom_range(0, 7) == 0);
      if (cyc == abort_at) begin
        bus.calc_init = 1'b0;
        bus.calc_abort = 1'b1;
        @(negedge clk);
        check("abort_wen", bus.wen_b, 0);
        @(posedge clk); #1;
        bus.calc_abort = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_state", bus.state, 0);
        q.delete();
        wq.delete();
        return;
      end
      @(negedge clk);
      h = q[0];
      stalled = (h.ph == 0) && !bus.hash_ready;
      check("busy", bus.busy, h.ph != 2);
      check("done", bus.done, h.ph == 2);
      check("sys_enable", bus.sys_enable, !stalled);
      check("sys_state", bus.sys_state, h.ss);
      if (h.a_v) begin
        check("addr_a", bus.addr_a, h.a);
        check("data_left", bus.data_left, bus.rd_a);
      end
      if (h.s_v) begin
        check("addr_s", bus.addr_s, h.s);
        check("data_right", bus.data_right, bus.rd_s);
      end
      if (h.b_v) begin
        check("addr_b_rd", bus.addr_b_rd, h.b);
        check("data_adder", bus.data_adder, bus.rd_b);
      end
      if (h.zero_ops)
        check("save_ops_zero", bus.data_left | bus.data_right | bus.data_adder, 0);
      if (stalled) check("stall_wen", bus.wen_b, 0);
      if (bus.busy) busy_cyc++;
      if (bus.wen_b) begin
        wr_cyc++;
        if (wq.size() == 0) check("extra_write", bus.wen_b, 0);
        else check("addr_b_wr", bus.addr_b_wr, wq.pop_front());
      end
      if (!stalled) void'(q.pop_front());
      cyc++;
      @(posedge clk); #1;
    end
    bus.calc_init = 1'b0;
    bus.hash_ready = 1'b1;
    check("op_timeout", q.size(), 0);
    check("writes_left", wq.size(), 0);
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_state", bus.state, 0);
  endtask

  initial begin
    int bc, wc, errs;
    bus.calc_init = 1'b0; bus.calc_abort = 1'b0; bus.mem_mode = '0; bus.matrix_size = '0;
    bus.base_a = '0; bus.base_s = '0; bus.base_b = '0; bus.hash_ready = 1'b1;
    bus.rd_a = '0; bus.rd_s = '0; bus.rd_b = '0;
    #3;
    check("rst_state", bus.state, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_wen", bus.wen_b, 0);
    check("rst_sys", {bus.sys_mode, bus.sys_state, bus.sys_enable}, 0);
    check("rst_addr", bus.addr_a | bus.addr_s | bus.addr_b_rd | bus.addr_b_wr, 0);
    #10 rst_n = 1'b1;

    ba = 32'h1000; bs = 32'h2000; bb = 32'h3000;
    run_op(1, 3, 0, -1, bc, wc);
    check("m1_busy_cycles", bc, 28);
    check("m1_writes", wc, 4);
    check("m1_sys_mode", bus.sys_mode, 1);

    run_op(2, 2, 0, -1, bc, wc);
    check("m2_busy_cycles", bc, 28);
    check("m2_writes", wc, 8);
    check("m2_sys_mode", bus.sys_mode, 0);

    run_op(1, 3, 2, -1, bc, wc);
    check("stall_busy_cycles", bc, 33);
`ifdef MEM_SEQ_CTRL_PERF_CNT_EN
    check("perf_stalls", bus.perf_stalls, 5);
    check("perf_cycles", bus.perf_cycles, bc);
`endif

    foreach (wq[i]) wq.delete(i);
    for (int m = 0; m < 8; m++) begin
      if (m == 1 || m == 2) continue;
      errs = 0;
      @(posedge clk); #1;
      bus.mem_mode = 3'(m); bus.matrix_size = 11'd2; bus.calc_init = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("err_busy", bus.busy, 0);
        if (bus.err) errs++;
        @(posedge clk); #1;
        bus.calc_init = 1'b0;
      end
      check("err_pulse", errs, 1);
    end

    run_op(1, 0, 0, -1, bc, wc);
    check("n0_busy_cycles", bc, 0);
    check("n0_writes", wc, 0);

    ba = 32'h0004_0000; bs = 32'h0005_0000; bb = 32'h0006_0000;
    run_op(2, 3, 0, LANES + 5, bc, wc);
    ba = 32'h0007_0000;
    run_op(1, 1, 0, -1, bc, wc);
    check("restart_busy_cycles", bc, 4 + 4 * DRAIN);

    @(posedge clk); #1;
    bus.mem_mode = 3'd2; bus.matrix_size = 11'd2; bus.calc_init = 1'b1;
    @(posedge clk); #1;
    bus.calc_init = 1'b0;
    repeat (22) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wen", bus.wen_b, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_addr", bus.addr_b_wr | bus.addr_b_rd | bus.addr_a, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle_wen", bus.wen_b, 0);
    check("arst_idle_state", bus.state, 0);

    for (int t = 0; t < 14; t++) begin
      ba = 32'h0001_0000 * $urandom_range(1, 255);
      bs = 32'h0001_0000 * $urandom_range(1, 255);
      bb = 32'h0001_0000 * $urandom_range(1, 255);
      run_op($urandom_range(1, 2), $urandom_range(1, 5), $urandom_range(0, 1), -1, bc, wc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
Parametrised address/sequencing controller for the systolic multiply array. It is the successor to the fixed 4-lane, 64-bit controller.
- Drives BRAM read/write addresses, array data and control for A·S (mode 1) and S·A (mode 2) products over LANES interleaved lanes.
- Adds start/busy/done handshake, backpressure stall on hash_ready, abort, and zero-size handling.
- Sits between the top-level command decoder and the BRAM/systolic array.

Parameters:
LANES, 4, lanes per row group (power of 2, ≥2)
DATA_W, 64, BRAM/array data width
ADDR_W, 32, address width
SIZE_W, 11, matrix-size width
A_STRIDE, 64, byte stride per A/B row
S_STRIDE, 32, byte stride per S row
DRAIN, 4, array drain depth in row groups (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
calc_init  in  1  start request, accepted only in IDLE
calc_abort  in  1  synchronous abort to IDLE
mem_mode  in  3  1=A·S, 2=S·A, others rejected
matrix_size  in  SIZE_W  N, rows per lane
base_a, base_s, base_b  in  ADDR_W  region bases
hash_ready  in  1  A-source valid; low stalls
rd_a, rd_s, rd_b  in  DATA_W  BRAM read data, 1-cycle latency
addr_a, addr_s, addr_b_rd, addr_b_wr  out  ADDR_W  BRAM addresses
wen_b  out  1  B write enable
data_left, data_right, data_adder  out  DATA_W  array operands
sys_mode  out  1  1=A·S, 0=S·A
sys_state  out  1  0=load, 1=compute
sys_enable  out  1  array advance
busy  out  1  high outside IDLE/DONE
done  out  1  1-cycle completion pulse
err  out  1  1-cycle pulse on illegal mem_mode
state  out  3  current state

Behaviour:
- Reset: state=IDLE. All outputs 0: addresses, wen_b, data, sys_*, busy, done, err, counters.
- Config capture: on accepted calc_init, register mode, N, bases, A_PLANE=N*A_STRIDE and S_PLANE=N*S_STRIDE (ADDR_W, wrap mod 2^ADDR_W). calc_init while busy is ignored.
- Counters: lane 0..LANES-1; line increments when lane wraps. Both clear on state entry.
- Stall: when hash_ready=0 in AS_CALC or SA_CALC:
  - lane, line and state hold.
  - sys_enable=0 and wen_b=0.
  - Addresses hold.
  - Otherwise sys_enable=1 in all non-IDLE states.
- Transitions out of IDLE on calc_init:
  - Mode 1 → AS_CALC.
  - Mode 2 → SA_LOAD.
  - Other mode → err pulse, stay IDLE.
  - N=0 → DONE directly.
- AS_CALC (sys_state=1):
  - addr_a = base_a + line*A_STRIDE + lane*A_PLANE.
  - addr_s = base_s + line*S_STRIDE + lane*S_PLANE.
  - data_left=rd_a, data_right=rd_s.
  - Exit to AS_SAVE after line=N-1, lane=LANES-1.
- AS_SAVE:
  - Lasts DRAIN groups, with data operands 0.
  - In the final group: wen_b=1, addr_b_wr = base_b + lane*LANES*A_STRIDE.
  - sys_state drops to 0 on entry to that final group.
  - Then → DONE.
- SA_LOAD (sys_state=0):
  - Lasts LANES cycles.
  - addr_s = base_s + (LANES-1-lane)*S_PLANE, data_right=rd_s.
  - Then → SA_CALC.
- SA_CALC (sys_state=1):
  - Lasts N+DRAIN groups.
  - For line<N: addr_a = base_a + line*A_STRIDE + lane*A_PLANE, data_left=rd_a; otherwise data_left=0.
  - For line≥DRAIN: addr_b_rd = base_b + (line-DRAIN)*A_STRIDE + lane*A_PLANE, and data_adder=rd_b.
  - Write-back: addr_b_wr is addr_b_rd delayed 1 unstalled cycle, with wen_b=1 on the corresponding delayed cycle. The delayed write completes even if it lands on the first DONE cycle.
  - Then → DONE.
- DONE: done=1 for one cycle, busy=0, then → IDLE.
- Abort: calc_abort in any state → IDLE next cycle. No done pulse; wen_b forced 0 that cycle. Abort has priority over stall.
- Async reset mid-operation: immediate return to reset values. No partial write is issued after rst_n deasserts.

Optional Feature:
MEM_SEQ_CTRL_PERF_CNT_EN:
- When defined, adds outputs perf_cycles[31:0] (busy cycles) and perf_stalls[31:0] (stalled cycles).
- Both clear on accepted calc_init, saturate at all-ones, and hold after done.
- When undefined, the ports and logic are absent.

Test Plan:
- Mode1, LANES=4, N=3, bases 0x1000/0x2000/0x3000, hash_ready=1 → AS_CALC addr_a sequence 0x1000,0x10C0,0x1180,0x1240,0x1040,…; done pulses exactly once; 4 wen_b cycles at 0x3000,0x3100,0x3200,0x3300.
- Mode2, N=2, DRAIN=4 → 4 SA_LOAD cycles with addr_s 0x2000+3*64,…,0x2000; 24 SA_CALC cycles; wen_b high on 8 cycles, first write to 0x3000.
- Mode1, N=3, hash_ready low for 5 cycles mid-AS_CALC → all counters/addresses frozen; total busy time extends by exactly 5 cycles; sys_enable=0 during the stall.
- mem_mode=3 → err pulse, busy stays 0. N=0 with mode1 → done on cycle 2 with no wen_b.
- calc_abort during SA_CALC, then calc_init mode1 N=1 → clean restart; first addr_a=base_a.
- With MEM_SEQ_CTRL_PERF_CNT_EN, run the stall scenario → perf_stalls=5; perf_cycles equals the measured busy count.
